// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the E stage and the mul/div sequencer.
// master = E stage / hazard side, slave = muldiv_sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             flush;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             done;

   modport master (
      output start, op, rs_val, rt_val, flush,
      input  hi_out, lo_out, busy, done
   );

   modport slave (
      input  start, op, rs_val, rt_val, flush,
      output hi_out, lo_out, busy, done
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; WIDTH CALC cycles + 1 FIX cycle, busy stalls E stage.
// No backpressure beyond busy; flush aborts without touching HI/LO. MULDIV_EARLY_TERM_EN shortens multiplies.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic           CLK,
   input logic           RST,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               is_div_q, is_div_d;
   logic               div0_q, div0_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               signed_op, rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;

   assign signed_op = ~bus.op[0];
   assign rs_neg    = signed_op & bus.rs_val[WIDTH-1];
   assign rt_neg    = signed_op & bus.rt_val[WIDTH-1];
   assign rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
   assign rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

   // Divide keeps {remainder, quotient/dividend} in acc and the divisor in mcand[WIDTH-1:0].
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, mcand_q[WIDTH-1:0]};
   assign rem_step  = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q[WIDTH-1:0]})
                             : div_shift[WIDTH-1:0];
   assign prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo_fix   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      is_div_d = is_div_q;
      div0_d   = div0_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               case (bus.op)
                  OP_MTHI: hi_d = bus.rs_val;
                  OP_MTLO: lo_d = bus.rs_val;
                  OP_MULT, OP_MULTU: begin
                     sa_d     = rs_neg;
                     sb_d     = rt_neg;
                     is_div_d = 1'b0;
                     div0_d   = 1'b0;
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, rs_mag};
                     mplier_d = rt_mag;
                     cnt_d    = '0;
                     state_d  = S_CALC;
                  end
                  OP_DIV, OP_DIVU: begin
                     sa_d     = rs_neg;
                     sb_d     = rt_neg;
                     is_div_d = 1'b1;
                     div0_d   = (bus.rt_val == '0);
                     mcand_d  = {{WIDTH{1'b0}}, rt_mag};
                     mplier_d = '0;
                     cnt_d    = '0;
                     // Divide by zero parks the raw dividend for HI and skips CALC.
                     acc_d    = {{WIDTH{1'b0}}, (bus.rt_val == '0) ? bus.rs_val : rs_mag};
                     state_d  = (bus.rt_val == '0) ? S_FIX : S_CALC;
                  end
                  default: ;
               endcase
            end
         end
         S_CALC: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (!is_div_q) begin
                  if (mplier_q[0]) acc_d = acc_q + mcand_q;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
               end else begin
                  acc_d = {rem_step, acc_q[WIDTH-2:0], div_ge};
               end
               if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
               if (!is_div_q && mplier_d == '0) state_d = S_FIX;
`endif
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (div0_q) begin
                  hi_d = acc_q[WIDTH-1:0];
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         is_div_q <= 1'b0;
         div0_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         is_div_q <= is_div_d;
         div0_q   <= div0_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic HI/LO model.
// Honors MULDIV_EARLY_TERM_EN when computing the expected busy length of multiplies.
module tb_muldiv_sequencer;
   logic CLK = 1'b0;
   logic RST;
   int   tests = 0;
   int   fails = 0;
   logic [31:0] hi_m, lo_m;

   always #5 CLK = ~CLK;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();
   muldiv_sequencer #(.WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected number of cycles busy stays high for a mul/div op.
   function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
      logic [31:0] mag;
      int n;
      if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_TERM_EN
      if (!op[1]) begin
         mag = (op == 3'b000 && b[31]) ? -b : b;
         n = 0;
         while (mag != 32'd0) begin
            n++;
            mag = mag >> 1;
         end
         if (n == 0) n = 1;
         return n + 1;
      end
`endif
      mag = b;
      n = 33;
      return n;
   endfunction

   task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p, q, r;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; hi_m = up[63:32]; lo_m = up[31:0]; end
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               hi_m = a; lo_m = 32'hFFFF_FFFF;
            end else if (op == 3'd2) begin
               q = sa / sb; r = sa % sb;
               lo_m = q[31:0]; hi_m = r[31:0];
            end else begin
               lo_m = a / b; hi_m = a % b;
            end
         end
         3'd4: hi_m = a;
         3'd5: lo_m = a;
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      int dn;
      @(negedge CLK);
      bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
      @(negedge CLK);
      bus.start = 1'b0;
      ref_apply(op, a, b);
      if (op < 3'd4) begin
         n = 0; dn = 0;
         while (bus.busy && n < 200) begin
            n++;
            if (bus.done) dn++;
            @(negedge CLK);
         end
         check_eq($sformatf("busy_len op%0d", op), 64'(n), 64'(exp_busy(op, b)));
         check_eq("done_while_busy", 64'(dn), 64'd0);
         check_eq("done_pulse", {63'd0, bus.done}, 64'd1);
         check_eq($sformatf("hi op%0d %h %h", op, a, b), {32'd0, bus.hi_out}, {32'd0, hi_m});
         check_eq($sformatf("lo op%0d %h %h", op, a, b), {32'd0, bus.lo_out}, {32'd0, lo_m});
         @(negedge CLK);
         check_eq("done_single", {63'd0, bus.done}, 64'd0);
      end else begin
         check_eq("idle_busy", {63'd0, bus.busy}, 64'd0);
         check_eq("idle_done", {63'd0, bus.done}, 64'd0);
         check_eq("idle_hi", {32'd0, bus.hi_out}, {32'd0, hi_m});
         check_eq("idle_lo", {32'd0, bus.lo_out}, {32'd0, lo_m});
      end
   endtask

   function automatic logic [31:0] rand_val();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0: v = 32'($urandom_range(0, 20));
         1: v = $urandom;
         2: v = -32'($urandom_range(1, 20));
         default: begin
            case ($urandom_range(0, 3))
               0: v = 32'd0;
               1: v = 32'h8000_0000;
               2: v = 32'hFFFF_FFFF;
               default: v = 32'h7FFF_FFFF;
            endcase
         end
      endcase
      return v;
   endfunction

   initial begin
      logic [31:0] b;
      RST = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
      hi_m = '0; lo_m = '0;
      repeat (3) @(negedge CLK);
      check_eq("rst_hi", {32'd0, bus.hi_out}, 64'd0);
      check_eq("rst_lo", {32'd0, bus.lo_out}, 64'd0);
      check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("rst_done", {63'd0, bus.done}, 64'd0);
      RST = 1'b1;

      // Directed cases
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
      run_op(3'd3, 32'd100, 32'd7);
      run_op(3'd2, -32'd7, 32'd2);
      run_op(3'd2, 32'h1234_5678, 32'd0);
      run_op(3'd4, 32'hA5A5_A5A5, 32'd0);
      run_op(3'd5, 32'h5A5A_5A5A, 32'd0);
      run_op(3'd1, 32'd0, 32'd0);
      run_op(3'd1, 32'd5, 32'd3);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd3, 32'hFFFF_FFFF, 32'd0);
      run_op(3'd6, 32'hDEAD_BEEF, 32'd1);
      run_op(3'd7, 32'hDEAD_BEEF, 32'd1);

      // flush in CALC
      run_op(3'd4, 32'h1111_2222, 32'd0);
      @(negedge CLK);
      bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd12345; bus.rt_val = 32'hFFFF_FFFF;
      @(negedge CLK);
      bus.start = 1'b0;
      repeat (9) @(negedge CLK);
      check_eq("flush_pre_busy", {63'd0, bus.busy}, 64'd1);
      bus.flush = 1'b1;
      @(negedge CLK);
      bus.flush = 1'b0;
      check_eq("flush_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("flush_done", {63'd0, bus.done}, 64'd0);
      check_eq("flush_hi", {32'd0, bus.hi_out}, {32'd0, hi_m});
      check_eq("flush_lo", {32'd0, bus.lo_out}, {32'd0, lo_m});
      repeat (3) @(negedge CLK);
      check_eq("flush_no_late_done", {63'd0, bus.done}, 64'd0);

      // flush in FIX (divide by zero goes straight to FIX)
      @(negedge CLK);
      bus.start = 1'b1; bus.op = 3'd2; bus.rs_val = 32'h7777_0000; bus.rt_val = 32'd0;
      @(negedge CLK);
      bus.start = 1'b0;
      check_eq("fix_busy", {63'd0, bus.busy}, 64'd1);
      bus.flush = 1'b1;
      @(negedge CLK);
      bus.flush = 1'b0;
      check_eq("fixflush_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("fixflush_done", {63'd0, bus.done}, 64'd0);
      check_eq("fixflush_hi", {32'd0, bus.hi_out}, {32'd0, hi_m});
      check_eq("fixflush_lo", {32'd0, bus.lo_out}, {32'd0, lo_m});

      // flush with start in IDLE: start ignored
      @(negedge CLK);
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.rs_val = 32'hCAFE_F00D;
      @(negedge CLK);
      bus.start = 1'b0; bus.flush = 1'b0;
      check_eq("flushstart_hi", {32'd0, bus.hi_out}, {32'd0, hi_m});
      check_eq("flushstart_busy", {63'd0, bus.busy}, 64'd0);

      // reset mid-operation
      @(negedge CLK);
      bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd99; bus.rt_val = 32'hFFFF_FFFF;
      @(negedge CLK);
      bus.start = 1'b0;
      repeat (4) @(negedge CLK);
      RST = 1'b0;
      #1;
      hi_m = '0; lo_m = '0;
      check_eq("midrst_hi", {32'd0, bus.hi_out}, 64'd0);
      check_eq("midrst_lo", {32'd0, bus.lo_out}, 64'd0);
      check_eq("midrst_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("midrst_done", {63'd0, bus.done}, 64'd0);
      @(negedge CLK);
      RST = 1'b1;

      // randomized ops
      for (int i = 0; i < 60; i++) begin
         b = ($urandom_range(0, 9) == 0) ? 32'd0 : rand_val();
         run_op(3'($urandom_range(0, 5)), rand_val(), b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide sequencer and HI/LO register owner for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and runs a shared radix-2 shift-add / restoring-divide datapath over multiple cycles.
- Drives `busy` into the hazard unit's mul/div stall input. Supplies `hi_out`/`lo_out` to the MFHI/MFLO path.

Parameters:
- WIDTH, 32, operand/HI/LO width; the counter width is derived as clog2(WIDTH)+1.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- start  input  1  op valid from E stage; sampled only in IDLE
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- rs_val  input  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data
- rt_val  input  WIDTH  rt operand: multiplier / divisor
- flush  input  1  abort in-flight op (exception / mispredict kill)
- hi_out  output  WIDTH  HI register
- lo_out  output  WIDTH  LO register
- busy  output  1  registered; high while state != IDLE
- done  output  1  registered; one-cycle pulse when a mul/div result commits

Behaviour:
- Reset (async, RST=0): state=IDLE; hi_out=0, lo_out=0, busy=0, done=0; counter and datapath registers cleared. Reset mid-operation aborts the op and also clears HI/LO.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MTHI/MTLO: HI (or LO) <= rs_val at that edge; stay in IDLE; busy stays 0; no done pulse.
- IDLE, start=1, op=mul/div:
  - Latch sign flags, abs(rs) and abs(rt); signed ops only, unsigned ops take raw values.
  - Go to CALC with cnt=0.
- IDLE, start=1, op=11x: ignored.
- DIV/DIVU with rt_val=0: go directly to FIX.
- Multiply datapath, CALC cycle:
  - If mplier[0]=1, acc += mcand.
  - 2*WIDTH-bit mcand shifts left; mplier shifts right; cnt++.
- Divide datapath, CALC cycle:
  - Restoring step: rem = {rem,quo_msb} - divisor if non-negative; quotient bit shifted in; cnt++.
- CALC -> FIX when cnt reaches WIDTH-1 at the end of the cycle, i.e. exactly WIDTH CALC cycles.
- FIX (1 cycle), at its edge:
  - Apply sign correction and write HI/LO.
  - Go to IDLE; busy drops; done=1 for the next cycle.
- Sign rules:
  - Product is negated (2*WIDTH-bit) when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend sign.
- Result mapping:
  - MULT/MULTU: HI=product[2W-1:W], LO=product[W-1:0].
  - DIV/DIVU: LO=quotient, HI=remainder.
- Divide by zero (decided): HI=rs_val, LO={WIDTH{1}}; busy high for 1 cycle.
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0 (wrap).
- Nominal latency: busy high 33 cycles after the start edge. HI/LO valid, busy=0 and done=1 in the cycle after the 33rd busy cycle.
- start while busy: ignored; upstream stall guarantees this does not occur.
- flush in CALC or FIX:
  - Return to IDLE next edge; HI/LO unchanged; no done pulse.
  - flush has priority over the FIX commit.
- flush in IDLE: no effect. flush with start in the same IDLE cycle: start is ignored.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - MULT/MULTU leaves CALC after any CALC cycle whose post-shift mplier==0.
  - Minimum is 1 CALC cycle.
  - Results are identical; only latency shrinks.
  - Divide is unaffected.
- Undefined: all mul/div ops always take WIDTH CALC cycles.

Test Plan:
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; done pulses once.
- DIVU rs=100, rt=7 -> LO=14, HI=2; DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0 -> busy 1 cycle, HI=0x12345678, LO=0xFFFFFFFF, done pulse.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A in consecutive IDLE cycles -> HI/LO updated on each edge, busy never asserts. Follow with MULTU 0,0 -> HI=LO=0.
- MULTU started, flush on CALC cycle 10 -> busy drops next cycle, HI/LO retain prior values, no done. Separately, assert RST on CALC cycle 5 -> HI=LO=0, busy=0 immediately.
- With MULDIV_EARLY_TERM_EN: MULTU rs=5, rt=3 -> 2 CALC cycles + FIX, busy 3 cycles, LO=15, HI=0. Without the macro, the same op gives busy 33 cycles and the same result.
